// File: rtl/zigzag_block_decoder.sv
// Zig-zag block decoder: scatters a stream of quantized coefficients into an
// 8x8 block using a 32-entry index pattern, dequantizes each element by the
// matching Q entry, and hands the finished block to the IDCT over valid/ready.
module zigzag_block_decoder #(
  parameter int N_COEF = 32,
  parameter int COEF_W = 64,
  parameter int IDX_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [COEF_W-1:0]                   in_coef,
  input  logic                                in_last,
  input  logic [N_COEF*IDX_W-1:0]             pattern,
  input  logic [(2**IDX_W)*COEF_W-1:0]        q,
  output logic                                blk_valid,
  input  logic                                blk_ready,
  output logic [(2**IDX_W)*COEF_W-1:0]        blk_data,
  output logic                                len_err,
  output logic [CNT_W-1:0]                    blk_count
);

  localparam int N_ELEM = 2**IDX_W;
  localparam int PTR_W  = $clog2(N_COEF);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_COEF - 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [PTR_W-1:0]    r_cnt;
  logic                r_len_err;
  logic [CNT_W-1:0]    r_blk_count;
  logic [COEF_W-1:0]   r_buf [N_ELEM];

  logic [IDX_W-1:0]    w_pat [N_COEF];
  logic [COEF_W-1:0]   w_q   [N_ELEM];
  logic [IDX_W-1:0]    w_idx;
  logic [COEF_W-1:0]   w_q_sel;
  logic [COEF_W-1:0]   w_prod;
  logic                w_accept;
  logic                w_handoff;
  logic                w_cnt_full;
  logic                w_end_beat;

  // Unpack the flat pattern and Q buses into indexable arrays.
  genvar gi;
  generate
    for (gi = 0; gi < N_COEF; gi++) begin : g_pat
      assign w_pat[gi] = pattern[gi*IDX_W +: IDX_W];
    end
    for (gi = 0; gi < N_ELEM; gi++) begin : g_q
      assign w_q[gi] = q[gi*COEF_W +: COEF_W];
    end
  endgenerate

  // Destination element and dequantized value for the current beat.
  // Only the low COEF_W bits of the product are kept, which is identical for
  // signed and unsigned operands, so no sign handling is needed here.
  assign w_idx      = w_pat[r_cnt];
  assign w_q_sel    = w_q[w_idx];
  assign w_prod     = in_coef * w_q_sel;
  assign w_cnt_full = (r_cnt == LAST_PTR);

  // Next-state and handshake decode; in_ready is forced low during reset.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    blk_valid    = 1'b0;
    w_accept     = 1'b0;
    w_handoff    = 1'b0;
    w_end_beat   = 1'b0;
    case (r_state)
      S_FILL: begin
        in_ready   = rst_n;
        w_accept   = in_valid && rst_n;
        w_end_beat = w_accept && (in_last || w_cnt_full);
        if (w_end_beat) begin
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        blk_valid = 1'b1;
        w_handoff = blk_ready;
        if (blk_ready) begin
          w_state_next = S_FILL;
        end
      end
      default: begin
        w_state_next = S_FILL;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Beat counter: advances per accept, restarts on handoff. After the 32nd
  // beat it wraps to zero on its own, ready for the next block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_handoff) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + PTR_W'(1);
    end
  end

  // Length error: in_last and a full count must coincide on the closing beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len_err <= 1'b0;
    end else if (w_handoff) begin
      r_len_err <= 1'b0;
    end else if (w_end_beat) begin
      r_len_err <= in_last ^ w_cnt_full;
    end
  end

  // Completed-block counter, wrapping naturally at its width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blk_count <= '0;
    end else if (w_handoff) begin
      r_blk_count <= r_blk_count + CNT_W'(1);
    end
  end

  // Block buffer: each element clears on reset or handoff and loads the
  // dequantized coefficient when the current beat targets it. A later beat
  // aimed at the same element simply overwrites the earlier value.
  generate
    for (gi = 0; gi < N_ELEM; gi++) begin : g_buf
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_buf[gi] <= '0;
        end else if (w_handoff) begin
          r_buf[gi] <= '0;
        end else if (w_accept && (w_idx == IDX_W'(gi))) begin
          r_buf[gi] <= w_prod;
        end
      end
      assign blk_data[gi*COEF_W +: COEF_W] = r_buf[gi];
    end
  endgenerate

  assign len_err   = r_len_err;
  assign blk_count = r_blk_count;

endmodule

// File: tb/tb_zigzag_block_decoder.sv
// Self-checking bench for zigzag_block_decoder: directed steps plus random
// blocks, compared against a behavioural block model kept in the bench.
module tb_zigzag_block_decoder;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [63:0]    in_coef = '0;
  logic           in_last = 1'b0;
  logic [191:0]   pattern = '0;
  logic [4095:0]  q = '0;
  logic           blk_valid;
  logic           blk_ready = 1'b0;
  logic [4095:0]  blk_data;
  logic           len_err;
  logic [15:0]    blk_count;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int             pat [32];
  logic [63:0]    qv  [64];
  logic [63:0]    exp_blk [64];
  int             k;
  int             exp_cnt;
  bit             exp_lerr;

  int zz [32] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
                  12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28};

  zigzag_block_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .in_last   (in_last),
    .pattern   (pattern),
    .q         (q),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .len_err   (len_err),
    .blk_count (blk_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int e = 0; e < 64; e++) exp_blk[e] = '0;
    k = 0;
    exp_lerr = 1'b0;
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < 32; i++) pattern[i*6 +: 6] = pat[i][5:0];
    for (int e = 0; e < 64; e++) q[e*64 +: 64] = qv[e];
  endtask

  task automatic check_data(input string tag);
    for (int e = 0; e < 64; e++)
      chk($sformatf("%s_e%0d", tag, e), blk_data[e*64 +: 64], exp_blk[e]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_blk_valid", {63'd0, blk_valid}, 64'd0);
    chk("rst_len_err", {63'd0, len_err}, 64'd0);
    chk("rst_blk_count", {48'd0, blk_count}, 64'd0);
    model_clear();
    exp_cnt = 0;
    rst_n = 1'b1;
    #1;
  endtask

  // One beat: wait for ready (bounded), present it for one edge, update model.
  task automatic beat(input logic [63:0] c, input bit last);
    int t = 0;
    int pos;
    in_valid = 1'b1;
    in_coef  = c;
    in_last  = last;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("beat_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    pos = pat[k];
    exp_blk[pos] = c * qv[pos];
    if (last || k == 31) exp_lerr = last ^ (k == 31);
    k++;
  endtask

  task automatic check_block(input string tag);
    chk({tag, "_valid"}, {63'd0, blk_valid}, 64'd1);
    chk({tag, "_lerr"}, {63'd0, len_err}, {63'd0, exp_lerr});
    chk({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
    check_data(tag);
    $display("[TB] block %s len=%0d len_err=%0b checked", tag, k, exp_lerr);
  endtask

  task automatic handoff(input string tag);
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 65536;
    model_clear();
    chk({tag, "_hs_valid"}, {63'd0, blk_valid}, 64'd0);
    chk({tag, "_hs_lerr"}, {63'd0, len_err}, 64'd0);
    chk({tag, "_hs_count"}, {48'd0, blk_count}, exp_cnt[63:0]);
    chk({tag, "_hs_ready"}, {63'd0, in_ready}, 64'd1);
    check_data({tag, "_clr"});
  endtask

  initial begin
    int len;
    bit lst;
    for (int i = 0; i < 32; i++) pat[i] = zz[i];
    for (int e = 0; e < 64; e++) qv[e] = 64'd1;
    apply_cfg();
    model_clear();
    exp_cnt = 0;

    // Step 1: reset state
    @(posedge clk); #1;
    do_reset();
    chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
    check_data("post_rst");

    // Step 2: zig-zag pattern, q=1, coefs 1..32
    for (int i = 1; i <= 32; i++) beat(64'(i), i == 32);
    check_block("zz");
    chk("zz_e0", blk_data[0 +: 64], 64'd1);
    chk("zz_e1", blk_data[64 +: 64], 64'd2);
    chk("zz_e8", blk_data[8*64 +: 64], 64'd3);
    chk("zz_e16", blk_data[16*64 +: 64], 64'd4);
    handoff("zz");
    chk("zz_count1", {48'd0, blk_count}, 64'd1);

    // Step 3: signed dequantization
    qv[0] = 64'd16;
    qv[1] = 64'd11;
    apply_cfg();
    beat(-64'sd3, 1'b0);
    beat(64'd5, 1'b1);
    check_block("deq");
    chk("deq_e0", blk_data[0 +: 64], 64'hFFFF_FFFF_FFFF_FFD0);
    chk("deq_e1", blk_data[64 +: 64], 64'd55);
    handoff("deq");

    // Step 4: short block then a 32-beat block without in_last
    for (int i = 0; i < 5; i++) beat({$urandom, $urandom}, i == 4);
    check_block("short");
    handoff("short");
    for (int i = 0; i < 32; i++) beat(64'($urandom_range(1, 1000)), 1'b0);
    check_block("nolast");
    chk("nolast_lerr1", {63'd0, len_err}, 64'd1);
    handoff("nolast");

    // Step 5: downstream stall with in_valid held high
    for (int i = 0; i < 32; i++) beat({$urandom, $urandom}, i == 31);
    in_valid = 1'b1;
    in_coef  = 64'h1234;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_ready", c), {63'd0, in_ready}, 64'd0);
      chk($sformatf("stall%0d_valid", c), {63'd0, blk_valid}, 64'd1);
      check_data($sformatf("stall%0d", c));
    end
    in_valid = 1'b0;
    check_block("stall");
    handoff("stall");
    beat(64'd77, 1'b1);
    check_block("single");
    handoff("single");

    // Step 6: reset mid-frame discards partial block and blk_count
    for (int i = 0; i < 10; i++) beat({$urandom, $urandom}, 1'b0);
    do_reset();
    for (int i = 0; i < 32; i++) beat(64'(i + 100), 1'b0);
    check_block("after_rst");
    handoff("after_rst");
    chk("after_rst_count", {48'd0, blk_count}, 64'd1);

    // Step 7: duplicate indices, later beat wins
    for (int e = 0; e < 64; e++) qv[e] = 64'd1;
    pat[0] = 7;
    pat[1] = 7;
    apply_cfg();
    beat(64'd4, 1'b0);
    beat(64'd9, 1'b1);
    check_block("dup");
    chk("dup_e7", blk_data[7*64 +: 64], 64'd9);
    handoff("dup");

    // Step 8: random patterns, Q matrices and block lengths
    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < 32; i++) pat[i] = $urandom_range(0, 63);
      for (int e = 0; e < 64; e++)
        qv[e] = (b % 2 == 0) ? 64'($urandom_range(1, 255)) : {$urandom, $urandom};
      apply_cfg();
      len = $urandom_range(1, 32);
      for (int i = 0; i < len; i++) begin
        lst = (i == len - 1) && ((len < 32) || ($urandom_range(0, 1) == 1));
        beat({$urandom, $urandom}, lst);
      end
      check_block($sformatf("rnd%0d", b));
      handoff($sformatf("rnd%0d", b));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/zigzag_block_decoder.md
Name: zigzag_block_decoder

Overview:
- Sequential receive-side counterpart of the zig-zag coefficient encoder.
- Accepts a stream of quantized DCT coefficients, one per cycle, over a valid/ready handshake.
- Scatters each coefficient into an 8x8 block at the position given by the 32-entry pattern, dequantizes it by the matching Q element, and zero-fills unsent positions.
- Presents the assembled 4096-bit block to the inverse DCT datapath through a second valid/ready handshake.

Parameters:
- N_COEF, 32, maximum coefficients per block.
- COEF_W, 64, width of one coefficient and one block element (two's complement).
- IDX_W, 6, width of one pattern index (0..63).
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset: one clock, synchronous, active-low.
- in_valid  input  1  coefficient valid.
- in_ready  output  1  block can accept a coefficient.
- in_coef  input  64  signed quantized coefficient.
- in_last  input  1  marks final coefficient of a block.
- pattern  input  192  32 x 6-bit element indices, entry i at bits [6i+5:6i]; held stable while a block is filling.
- q  input  4096  64 x 64-bit quantization matrix, element e at [64e+63:64e]; held stable while filling.
- blk_valid  output  1  assembled block available.
- blk_ready  input  1  downstream accepts block.
- blk_data  output  4096  dequantized 8x8 block, element e at [64e+63:64e].
- len_err  output  1  current block ended with in_last and count 32 disagreeing; valid with blk_valid.
- blk_count  output  16  number of blocks handed off, wraps.

Behaviour:
- Reset (rst_n low at a rising edge): state FILL, coefficient counter 0, buffer all zero, blk_valid 0, len_err 0, blk_count 0.
- in_ready is 0 while rst_n is low; otherwise in_ready = (state == FILL).
- States: FILL and HOLD.
- FILL: on in_valid && in_ready, write buffer[pattern[cnt]] = low 64 bits of (in_coef x q[pattern[cnt]]).
  - Product is the two's-complement low 64 bits; no saturation and no rounding.
  - cnt increments on each accept.
- End of block: when an accepted beat has in_last=1 or cnt==31, the next state is HOLD.
  - blk_valid goes high the cycle after the final accept (latency 1).
  - len_err = (in_last XOR (cnt==31)) for that beat.
- HOLD: blk_data and len_err are stable and in_ready is 0; in_valid is ignored and no coefficient is consumed.
- On blk_valid && blk_ready:
  - the buffer is cleared to zero, cnt goes to 0, blk_count increments, and the state returns to FILL next cycle;
  - blk_valid and len_err drop next cycle.
- Minimum period is 33 cycles per full block (32 accepts plus 1 handoff cycle).
- blk_valid never drops without a handshake except by reset.
- Duplicate indices in pattern: the later beat overwrites the earlier one; no error is flagged.
- Short block (in_last before 32 beats): unwritten positions stay zero, len_err=1.
- Beat 32 without in_last: the block is closed anyway and len_err=1. The next accepted beat starts a new block.
- Reset mid-frame or in HOLD takes priority over everything. The partial block is discarded and its data never appears on blk_data.
- blk_count wraps from 0xFFFF to 0.
- blk_data is driven directly from the buffer register; it equals the buffer at all times, including during FILL. It is meaningful only while blk_valid=1.

Test Plan:
- Pattern = standard JPEG zig-zag (0,1,8,16,9,2,3,10,...), q all 1, coefs 1..32 with in_last on the 32nd -> blk_valid one cycle after the last accept; element 0=1, 1=2, 8=3, 16=4; the 32 unsent positions are 0; len_err=0; blk_count=1 after handshake.
- Single-element check, q[0]=16, first coef = -3 -> element 0 = 0xFFFFFFFFFFFFFFD0 (-48); q[1]=11, coef 5 -> element 1 = 55.
- in_last on the 5th beat -> block holds 5 nonzero entries, all others 0, len_err=1. Then 32 beats without in_last -> block closed after the 32nd, len_err=1.
- blk_ready held low 10 cycles with in_valid high -> in_ready=0 and blk_data unchanged throughout. After handshake, the next block with only 1 coef + in_last shows zeros everywhere except that element.
- rst_n low one cycle after 10 accepted beats -> blk_valid=0 and blk_count=0. The next 32 beats produce a block containing no data from the aborted frame.
- pattern entries 0 and 1 both = 7, coefs 4 then 9, q=1 -> element 7 = 9.
